// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main controller: opcodes, FSM states,
// datapath mux selects, error codes and the packed control-strobe bundle.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_ILLEGAL = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_t;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_RD    = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WR    = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12,
    S_HALT      = 4'd15
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

  // States that hold a memory request open and therefore run the wait timer.
  function automatic logic is_wait_state(state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: instruction opcode and memory ready in, control
// strobes and status out. master = controller, slave = datapath.
interface multicycle_control_if;

  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       instr_done;
  logic       halted;
  logic [1:0] err_code;
  logic [3:0] state_o;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, halted, err_code, state_o
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, halted, err_code, state_o
  );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of one memory access; expired is combinational and
// fires in the cycle that would be the MEM_TIMEOUT-th stall (0 disables the limit).
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int LIM = (MEM_TIMEOUT > 1) ? MEM_TIMEOUT - 1 : 0;
  localparam int CW  = (LIM > 0) ? $clog2(LIM + 1) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

  // cnt holds the stalls already seen, so the limit cycle is the one where cnt == LIM.
  assign expired = (MEM_TIMEOUT != 0) && en && (cnt == CW'(LIM));

endmodule

// File: rtl/multicycle_control.sv
// Moore main controller for the multi-cycle MIPS datapath; outputs decode from state
// (FETCH/MEM_WR strobes also gated by mem_ready); memory stalls are bounded by mem_wait_timer.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input logic                 clk,
  input logic                 rst_n,
  multicycle_control_if.master bus
);

  state_t state_q, state_d;
  err_t   err_q, err_d;
  ctrl_t  ctl;
  logic   tmr_en;
  logic   tmr_expired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign tmr_en = is_wait_state(state_q) && !bus.mem_ready;

  // Any state change clears the counter, which covers entry into every wait state.
  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state_d != state_q),
    .en     (tmr_en),
    .expired(tmr_expired)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    ctl     = '0;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = SRCB_FOUR;
        ctl.alu_op    = ALU_ADD;
        ctl.pc_source = PCSRC_ALU;
        if (bus.mem_ready) begin
          ctl.ir_write = 1'b1;
          ctl.pc_write = 1'b1;
          state_d      = S_DECODE;
        end else if (tmr_expired) begin
          state_d = S_HALT;
          err_d   = ERR_TIMEOUT;
        end
      end

      S_DECODE: begin
        ctl.alu_src_b = SRCB_IMM_SH;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          default: begin
            state_d = S_HALT;
            err_d   = ERR_ILLEGAL;
          end
        endcase
      end

      S_MEM_ADDR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        state_d       = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        ctl.mem_read = 1'b1;
        ctl.i_or_d   = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_MEM_WB;
        end else if (tmr_expired) begin
          state_d = S_HALT;
          err_d   = ERR_TIMEOUT;
        end
      end

      S_MEM_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
        ctl.instr_done = 1'b1;
        state_d        = S_FETCH;
      end

      S_MEM_WR: begin
        ctl.mem_write = 1'b1;
        ctl.i_or_d    = 1'b1;
        if (bus.mem_ready) begin
          ctl.instr_done = 1'b1;
          state_d        = S_FETCH;
        end else if (tmr_expired) begin
          state_d = S_HALT;
          err_d   = ERR_TIMEOUT;
        end
      end

      S_R_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_RT;
        ctl.alu_op    = ALU_FUNCT;
        state_d       = S_R_WB;
      end

      S_R_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.reg_dst    = 1'b1;
        ctl.instr_done = 1'b1;
        state_d        = S_FETCH;
      end

      S_BRANCH: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_src_b     = SRCB_RT;
        ctl.alu_op        = ALU_SUB;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = PCSRC_ALUOUT;
        ctl.instr_done    = 1'b1;
        state_d           = S_FETCH;
      end

      S_JUMP: begin
        ctl.pc_write   = 1'b1;
        ctl.pc_source  = PCSRC_JUMP;
        ctl.instr_done = 1'b1;
        state_d        = S_FETCH;
      end

      S_ADDI_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        state_d       = S_ADDI_WB;
      end

      S_ADDI_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.reg_dst    = 1'b0;
        ctl.instr_done = 1'b1;
        state_d        = S_FETCH;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  assign bus.pc_write      = ctl.pc_write;
  assign bus.pc_write_cond = ctl.pc_write_cond;
  assign bus.i_or_d        = ctl.i_or_d;
  assign bus.mem_read      = ctl.mem_read;
  assign bus.mem_write     = ctl.mem_write;
  assign bus.ir_write      = ctl.ir_write;
  assign bus.mem_to_reg    = ctl.mem_to_reg;
  assign bus.reg_dst       = ctl.reg_dst;
  assign bus.reg_write     = ctl.reg_write;
  assign bus.alu_src_a     = ctl.alu_src_a;
  assign bus.alu_src_b     = ctl.alu_src_b;
  assign bus.alu_op        = ctl.alu_op;
  assign bus.pc_source     = ctl.pc_source;
  assign bus.instr_done    = ctl.instr_done;
  assign bus.halted        = (state_q == S_HALT);
  assign bus.err_code      = err_q;
  assign bus.state_o       = state_q;

endmodule
